wb_bus8_bridge: RTL and testbench

Wishbone 16-bit to 8-bit width bridge on one slave port of the system Wishbone switch, in front of 8-bit peripherals (UART, PS/2, legacy I/O). Each 16-bit classic cycle becomes one or two 8-bit classic cycles, one per selected byte lane. The upstream ack is raised once all lanes are done. A per-byte watchdog completes the access if the 8-bit slave never acks, so the shared bus cannot stall.

---
 rtl/wb_bus8_bridge_pkg.sv | 26 ++
 rtl/wb_bus8_bridge_if.sv | 28 ++
 rtl/wb_bus8_wdog.sv | 37 +++
 rtl/wb_bus8_bridge.sv | 191 +++++++++++++++++++
 tb/tb_wb_bus8_bridge.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_bus8_bridge_pkg.sv
// Shared definitions for the 16-to-8 bit Wishbone bridge: state encodings,
// parameter defaults and the latched request record.
package wb_bus8_bridge_pkg;

    localparam int unsigned   TimeoutDefault = 255;
    localparam logic [7:0]    ToDataDefault  = 8'hFF;
    localparam int unsigned   WdogCntW       = 8;

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StLo   = 3'd1;
    localparam logic [2:0] StGap  = 3'd2;
    localparam logic [2:0] StHi   = 3'd3;
    localparam logic [2:0] StDone = 3'd4;

    // Only the parts of the request still needed after the first lane starts.
    typedef struct packed {
        logic [19:0] adr;
        logic        sel_hi;
        logic [7:0]  dat_hi;
    } req_t;

    function automatic logic [20:0] lane_adr(input logic [19:0] word_adr, input logic hi);
        return {word_adr, hi};
    endfunction

endpackage

// File: rtl/wb_bus8_bridge_if.sv
// Wishbone classic bus bundle; instantiated once per side with its own widths.
interface wb_bus8_bridge_if #(
    parameter int unsigned DatW = 16,
    parameter int unsigned AdrW = 20,
    parameter int unsigned SelW = 2
) ();

    logic [DatW-1:0] dat_w;
    logic [DatW-1:0] dat_r;
    logic [AdrW-1:0] adr;
    logic [2:0]      cti;
    logic [SelW-1:0] sel;
    logic            we;
    logic            cyc;
    logic            stb;
    logic            ack;

    modport master (
        output dat_w, adr, cti, sel, we, cyc, stb,
        input  dat_r, ack
    );

    modport slave (
        input  dat_w, adr, cti, sel, we, cyc, stb,
        output dat_r, ack
    );

endinterface

// File: rtl/wb_bus8_wdog.sv
// Per-byte ack watchdog: pulses timeout when a lane has waited TIMEOUT cycles
// without an ack. TIMEOUT of zero disables it.
module wb_bus8_wdog
    import wb_bus8_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = TimeoutDefault
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clear,
    input  logic enable,
    input  logic ack,
    output logic timeout
);

    if (TIMEOUT != 0) begin : g_wdog
        localparam logic [WdogCntW-1:0] Limit = WdogCntW'(TIMEOUT - 1);

        logic [WdogCntW-1:0] count_q;

        always_ff @(posedge sys_clk) begin
            if (sys_rst || clear) begin
                count_q <= '0;
            end else if (enable && !ack) begin
                count_q <= count_q + WdogCntW'(1);
            end
        end

        // An ack in the same cycle suppresses the pulse so real data wins.
        assign timeout = enable && !ack && (count_q == Limit);
    end else begin : g_no_wdog
        logic unused_wdog;
        assign unused_wdog = sys_clk ^ sys_rst ^ clear ^ enable ^ ack;
        assign timeout     = 1'b0;
    end

endmodule

// File: rtl/wb_bus8_bridge.sv
// 16-bit to 8-bit Wishbone classic width bridge: one downstream cycle per
// selected byte lane, upstream ack once all lanes finish or time out.
module wb_bus8_bridge
    import wb_bus8_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = TimeoutDefault,
    parameter logic [7:0]  TO_DATA = ToDataDefault
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    wb_bus8_bridge_if.slave  wbs,
    wb_bus8_bridge_if.master wbm
);

    logic [2:0]  state_q, state_d;
    req_t        req_q, req_d;
    logic [15:0] rdata_q, rdata_d;
    logic        ack_q, ack_d;
    logic [15:0] sdat_q, sdat_d;
    logic        mcyc_q, mcyc_d;
    logic        mstb_q, mstb_d;
    logic        mwe_q, mwe_d;
    logic [20:0] madr_q, madr_d;
    logic [7:0]  mdat_q, mdat_d;

    logic [7:0]  lane_byte;
    logic        in_lane;
    logic        enter_lane;
    logic        timeout;

    logic        unused_cti;
    assign unused_cti = ^wbs.cti;

    assign in_lane    = (state_q == StLo) || (state_q == StHi);
    assign enter_lane = ((state_d == StLo) || (state_d == StHi)) && (state_d != state_q);

    wb_bus8_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clear   (enter_lane),
        .enable  (in_lane),
        .ack     (wbm.ack),
        .timeout (timeout)
    );

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        rdata_d   = rdata_q;
        ack_d     = 1'b0;
        sdat_d    = sdat_q;
        mcyc_d    = mcyc_q;
        mstb_d    = mstb_q;
        mwe_d     = mwe_q;
        madr_d    = madr_q;
        mdat_d    = mdat_q;
        lane_byte = wbm.ack ? wbm.dat_r : TO_DATA;

        case (state_q)
            StIdle: begin
                if (wbs.cyc && wbs.stb && !ack_q) begin
                    req_d.adr    = wbs.adr;
                    req_d.sel_hi = wbs.sel[1];
                    req_d.dat_hi = wbs.dat_w[15:8];
                    rdata_d      = '0;
                    if (wbs.sel[0]) begin
                        state_d = StLo;
                        mcyc_d  = 1'b1;
                        mstb_d  = 1'b1;
                        mwe_d   = wbs.we;
                        madr_d  = lane_adr(wbs.adr, 1'b0);
                        mdat_d  = wbs.dat_w[7:0];
                    end else if (wbs.sel[1]) begin
                        state_d = StHi;
                        mcyc_d  = 1'b1;
                        mstb_d  = 1'b1;
                        mwe_d   = wbs.we;
                        madr_d  = lane_adr(wbs.adr, 1'b1);
                        mdat_d  = wbs.dat_w[15:8];
                    end else begin
                        state_d = StDone;
                        ack_d   = 1'b1;
                        sdat_d  = '0;
                    end
                end
            end

            StLo: begin
                if (!wbs.cyc) begin
                    state_d = StIdle;
                    mcyc_d  = 1'b0;
                    mstb_d  = 1'b0;
                    mwe_d   = 1'b0;
                end else if (wbm.ack || timeout) begin
                    rdata_d[7:0] = lane_byte;
                    if (req_q.sel_hi) begin
                        // Drop stb for a cycle so combinational-ack slaves see a new strobe.
                        state_d = StGap;
                        mstb_d  = 1'b0;
                    end else begin
                        state_d = StDone;
                        ack_d   = 1'b1;
                        sdat_d  = rdata_d;
                        mcyc_d  = 1'b0;
                        mstb_d  = 1'b0;
                        mwe_d   = 1'b0;
                    end
                end
            end

            StGap: begin
                if (!wbs.cyc) begin
                    state_d = StIdle;
                    mcyc_d  = 1'b0;
                    mstb_d  = 1'b0;
                    mwe_d   = 1'b0;
                end else begin
                    state_d = StHi;
                    mstb_d  = 1'b1;
                    madr_d  = lane_adr(req_q.adr, 1'b1);
                    mdat_d  = req_q.dat_hi;
                end
            end

            StHi: begin
                if (!wbs.cyc) begin
                    state_d = StIdle;
                    mcyc_d  = 1'b0;
                    mstb_d  = 1'b0;
                    mwe_d   = 1'b0;
                end else if (wbm.ack || timeout) begin
                    rdata_d[15:8] = lane_byte;
                    state_d       = StDone;
                    ack_d         = 1'b1;
                    sdat_d        = rdata_d;
                    mcyc_d        = 1'b0;
                    mstb_d        = 1'b0;
                    mwe_d         = 1'b0;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= StIdle;
            req_q   <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            sdat_q  <= '0;
            mcyc_q  <= 1'b0;
            mstb_q  <= 1'b0;
            mwe_q   <= 1'b0;
            madr_q  <= '0;
            mdat_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            sdat_q  <= sdat_d;
            mcyc_q  <= mcyc_d;
            mstb_q  <= mstb_d;
            mwe_q   <= mwe_d;
            madr_q  <= madr_d;
            mdat_q  <= mdat_d;
        end
    end

    assign wbs.ack   = ack_q;
    assign wbs.dat_r = sdat_q;

    assign wbm.cyc   = mcyc_q;
    assign wbm.stb   = mstb_q;
    assign wbm.we    = mwe_q;
    assign wbm.adr   = madr_q;
    assign wbm.dat_w = mdat_q;
    assign wbm.sel   = 1'b1;
    assign wbm.cti   = 3'b000;

endmodule

// File: tb/tb_wb_bus8_bridge.sv
// Bench for wb_bus8_bridge: timeline model of each transaction checked every
// cycle, plus hand-computed expectations for the directed cases.
module tb_wb_bus8_bridge;

    localparam int Tmo  = 16;
    localparam int MaxC = 48;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    wb_bus8_bridge_if #(.DatW(16), .AdrW(20), .SelW(2)) wbs ();
    wb_bus8_bridge_if #(.DatW(8),  .AdrW(21), .SelW(1)) wbm ();

    wb_bus8_bridge #(
        .TIMEOUT (Tmo),
        .TO_DATA (8'hFF)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .wbs     (wbs),
        .wbm     (wbm)
    );

    always #5 sys_clk = ~sys_clk;

    // 8-bit slave: acks after wait_* stb cycles; a negative wait never acks.
    int         wait_lo = 0;
    int         wait_hi = 0;
    logic [7:0] data_lo = 8'h00;
    logic [7:0] data_hi = 8'h00;
    int         st_cnt  = 0;
    int         cur_wait;

    always_comb cur_wait = wbm.adr[0] ? wait_hi : wait_lo;
    assign wbm.ack   = wbm.cyc && wbm.stb && (cur_wait >= 0) && (st_cnt == cur_wait);
    assign wbm.dat_r = wbm.adr[0] ? data_hi : data_lo;

    always @(posedge sys_clk) begin
        if (wbm.cyc && wbm.stb && !wbm.ack) st_cnt <= st_cnt + 1;
        else                                st_cnt <= 0;
    end

    int n_err = 0;
    int n_chk = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Expected per-cycle timeline; index 0 is the cycle presenting the request.
    logic        exp_ack  [MaxC];
    logic        exp_cyc  [MaxC];
    logic        exp_stb  [MaxC];
    logic [20:0] exp_adr  [MaxC];
    logic [7:0]  exp_wdat [MaxC];
    logic        exp_we;
    logic [15:0] exp_rdat;
    int          exp_ack_cyc;
    int          exp_end;

    int          obs_ack;
    logic [15:0] obs_rdat;
    logic [20:0] obs_adr [$];
    logic [7:0]  obs_wdat [$];

    task automatic build_model(input logic [1:0] sel, input logic we, input logic [19:0] adr,
                               input logic [15:0] dat, input int abort_at);
        int          t;
        int          w;
        int          dur;
        logic [7:0]  b;
        logic [15:0] rd;
        for (int k = 0; k < MaxC; k++) begin
            exp_ack[k]  = 1'b0;
            exp_cyc[k]  = 1'b0;
            exp_stb[k]  = 1'b0;
            exp_adr[k]  = '0;
            exp_wdat[k] = '0;
        end
        exp_we = we;
        rd     = 16'h0000;
        t      = 1;
        for (int lane = 0; lane < 2; lane++) begin
            if (sel[lane]) begin
                if (lane == 1 && sel[0]) begin
                    exp_cyc[t] = 1'b1;
                    t++;
                end
                w = (lane == 1) ? wait_hi : wait_lo;
                if (w >= 0 && w < Tmo) begin
                    dur = w + 1;
                    b   = (lane == 1) ? data_hi : data_lo;
                end else begin
                    dur = Tmo;
                    b   = 8'hFF;
                end
                for (int k = t; k < t + dur; k++) begin
                    exp_cyc[k]  = 1'b1;
                    exp_stb[k]  = 1'b1;
                    exp_adr[k]  = {adr, (lane == 1)};
                    exp_wdat[k] = (lane == 1) ? dat[15:8] : dat[7:0];
                end
                if (lane == 1) rd[15:8] = b;
                else           rd[7:0]  = b;
                t += dur;
            end
        end
        exp_ack[t]  = 1'b1;
        exp_rdat    = rd;
        exp_ack_cyc = t;
        exp_end     = t + 1;
        if (abort_at > 0) begin
            for (int k = abort_at + 1; k < MaxC; k++) begin
                exp_ack[k] = 1'b0;
                exp_cyc[k] = 1'b0;
                exp_stb[k] = 1'b0;
            end
            exp_end = abort_at + 3;
        end
    endtask

    task automatic compare(input string name, input int k);
        chk($sformatf("%s.ack@%0d", name, k), 32'(wbs.ack), 32'(exp_ack[k]));
        chk($sformatf("%s.cyc@%0d", name, k), 32'(wbm.cyc), 32'(exp_cyc[k]));
        chk($sformatf("%s.stb@%0d", name, k), 32'(wbm.stb), 32'(exp_stb[k]));
        if (exp_stb[k]) begin
            chk($sformatf("%s.adr@%0d", name, k), 32'(wbm.adr), 32'(exp_adr[k]));
            chk($sformatf("%s.we@%0d", name, k), 32'(wbm.we), 32'(exp_we));
            if (exp_we) chk($sformatf("%s.wdat@%0d", name, k), 32'(wbm.dat_w), 32'(exp_wdat[k]));
        end
        if (exp_ack[k]) chk($sformatf("%s.rdat@%0d", name, k), 32'(wbs.dat_r), 32'(exp_rdat));
        if (wbs.ack && obs_ack < 0) begin
            obs_ack  = k;
            obs_rdat = wbs.dat_r;
        end
        if (wbm.stb && wbm.ack) begin
            obs_adr.push_back(wbm.adr);
            obs_wdat.push_back(wbm.dat_w);
        end
    endtask

    // Starts in the current cycle (caller sits just after a rising edge).
    task automatic run(input string name, input logic [1:0] sel, input logic we,
                       input logic [19:0] adr, input logic [15:0] dat,
                       input int w_lo, input int w_hi, input logic [7:0] d_lo,
                       input logic [7:0] d_hi, input int abort_at);
        int drop_at;
        wait_lo = w_lo;
        wait_hi = w_hi;
        data_lo = d_lo;
        data_hi = d_hi;
        build_model(sel, we, adr, dat, abort_at);
        drop_at = (abort_at > 0) ? abort_at : exp_ack_cyc;
        obs_ack = -1;
        obs_adr.delete();
        obs_wdat.delete();
        wbs.adr   = adr;
        wbs.sel   = sel;
        wbs.we    = we;
        wbs.dat_w = dat;
        wbs.cti   = 3'b111;
        wbs.cyc   = 1'b1;
        wbs.stb   = 1'b1;
        for (int k = 0; k < exp_end; k++) begin
            if (k == drop_at) begin
                wbs.cyc = 1'b0;
                wbs.stb = 1'b0;
            end
            @(negedge sys_clk);
            compare(name, k);
            @(posedge sys_clk);
            #1;
        end
        wbs.cyc = 1'b0;
        wbs.stb = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, ".ack"},  32'(wbs.ack),   32'h0);
        chk({name, ".sdat"}, 32'(wbs.dat_r), 32'h0);
        chk({name, ".cyc"},  32'(wbm.cyc),   32'h0);
        chk({name, ".stb"},  32'(wbm.stb),   32'h0);
        chk({name, ".we"},   32'(wbm.we),    32'h0);
        chk({name, ".madr"}, 32'(wbm.adr),   32'h0);
        chk({name, ".mdat"}, 32'(wbm.dat_w), 32'h0);
    endtask

    initial begin
        wbs.adr   = '0;
        wbs.sel   = '0;
        wbs.we    = 1'b0;
        wbs.dat_w = '0;
        wbs.cti   = '0;
        wbs.cyc   = 1'b0;
        wbs.stb   = 1'b0;
        sys_rst   = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        chk_reset_outputs("reset");
        sys_rst = 1'b0;

        run("rd11", 2'b11, 1'b0, 20'h0_0100, 16'h0000, 0, 0, 8'h34, 8'h12, 0);
        chk("rd11.ack_cycle", 32'(obs_ack), 32'd4);
        chk("rd11.rdata", 32'(obs_rdat), 32'h1234);
        chk("rd11.nbytes", 32'(obs_adr.size()), 32'd2);
        if (obs_adr.size() == 2) begin
            chk("rd11.adr0", 32'(obs_adr[0]), 32'h000200);
            chk("rd11.adr1", 32'(obs_adr[1]), 32'h000201);
        end

        run("wr10", 2'b10, 1'b1, 20'h0_0010, 16'hAB00, 0, 0, 8'h00, 8'h00, 0);
        chk("wr10.ack_cycle", 32'(obs_ack), 32'd2);
        chk("wr10.nbytes", 32'(obs_adr.size()), 32'd1);
        if (obs_adr.size() == 1) begin
            chk("wr10.adr", 32'(obs_adr[0]), 32'h000021);
            chk("wr10.wdat", 32'(obs_wdat[0]), 32'hAB);
        end

        run("tmo01", 2'b01, 1'b0, 20'h0_0042, 16'h0000, -1, 0, 8'h11, 8'h22, 0);
        chk("tmo01.ack_cycle", 32'(obs_ack), 32'd17);
        chk("tmo01.rdata", 32'(obs_rdat), 32'h00FF);

        run("sel00", 2'b00, 1'b0, 20'h0_0077, 16'h0000, 0, 0, 8'h55, 8'h66, 0);
        chk("sel00.ack_cycle", 32'(obs_ack), 32'd1);
        chk("sel00.rdata", 32'(obs_rdat), 32'h0000);
        chk("sel00.nbytes", 32'(obs_adr.size()), 32'd0);

        run("wait11", 2'b11, 1'b0, 20'hF_FFFF, 16'h0000, 2, 1, 8'h9C, 8'hE1, 0);
        chk("wait11.ack_cycle", 32'(obs_ack), 32'd7);
        chk("wait11.rdata", 32'(obs_rdat), 32'hE19C);

        run("hitmo", 2'b11, 1'b1, 20'h0_1234, 16'hBEEF, 0, -1, 8'h00, 8'h00, 0);
        chk("hitmo.ack_cycle", 32'(obs_ack), 32'd19);
        chk("hitmo.rdata", 32'(obs_rdat), 32'hFF00);

        run("abort", 2'b11, 1'b0, 20'h0_0300, 16'h0000, 0, 0, 8'hA1, 8'hA2, 2);
        chk("abort.no_ack", 32'(obs_ack), 32'hFFFF_FFFF);
        chk("abort.nbytes", 32'(obs_adr.size()), 32'd1);

        run("race", 2'b01, 1'b0, 20'h0_0005, 16'h0000, Tmo - 1, 0, 8'h5A, 8'h00, 0);
        chk("race.ack_cycle", 32'(obs_ack), 32'd17);
        chk("race.rdata", 32'(obs_rdat), 32'h005A);

        // Reset while the high lane is waiting on a silent slave.
        wait_lo = 0;
        wait_hi = -1;
        data_lo = 8'h3C;
        data_hi = 8'h00;
        build_model(2'b11, 1'b1, 20'h0_0ABC, 16'h7788, 0);
        wbs.adr   = 20'h0_0ABC;
        wbs.sel   = 2'b11;
        wbs.we    = 1'b1;
        wbs.dat_w = 16'h7788;
        wbs.cyc   = 1'b1;
        wbs.stb   = 1'b1;
        obs_ack   = -1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) sys_rst = 1'b1;
            @(negedge sys_clk);
            compare("rst_hi", k);
            @(posedge sys_clk);
            #1;
        end
        wbs.cyc = 1'b0;
        wbs.stb = 1'b0;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk_reset_outputs("rst_hi");
        @(posedge sys_clk);
        #1;
        @(negedge sys_clk);
        chk("rst_hi.no_ack", 32'(wbs.ack), 32'h0);
        chk("rst_hi.idle_cyc", 32'(wbm.cyc), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
